// File: rtl/mips_pipeline_cpu.sv
// Five-stage MIPS integer pipeline with on-chip byte memories and register file.
// Control flow resolves in ID; EX forwards from EX/MEM then MEM/WB; DIVU feeds HI/LO.

module mips_byte_mem #(
    parameter int BYTES = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(BYTES);

    reg [7:0] mem_array[0:BYTES-1];

    logic [AW-1:0] a0, a1, a2, a3;
    logic          unused_addr_bits;

    assign a0 = addr[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign rdata = {mem_array[a3], mem_array[a2], mem_array[a1], mem_array[a0]};
    assign unused_addr_bits = ^addr[31:AW];

    // Plain always so benches can preload mem_array hierarchically.
    always @(posedge clk) begin
        if (we) begin
            mem_array[a0] <= wdata[7:0];
            mem_array[a1] <= wdata[15:8];
            mem_array[a2] <= wdata[23:16];
            mem_array[a3] <= wdata[31:24];
        end
    end
endmodule

module mips_reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    reg [31:0] file_array[0:31];

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 :
                     (we && waddr == raddr_a) ? wdata : file_array[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 :
                     (we && waddr == raddr_b) ? wdata : file_array[raddr_b];

    always @(posedge clk) begin
        if (we && waddr != 5'd0) begin
            file_array[waddr] <= wdata;
        end
    end
endmodule

module mips_pipeline_cpu #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input logic clk,
    input logic rst
);
    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT,
        ALU_SLL, ALU_MFHI, ALU_MFLO, ALU_DIVU
    } alu_op_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    typedef struct packed {
        alu_op_e     op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        src_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] store;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dest;
        logic [31:0] wd;
    } mem_wb_t;

    logic [31:0] pc, ID_instr, wb_wd;
    logic [5:0]  opcode, funct;

    logic [31:0] pc_q, pc_d, hi_q, hi_d, lo_q, lo_d;
    if_id_t      if_id_q, if_id_d;
    id_ex_t      id_ex_q, id_ex_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [31:0] imem_rdata, dmem_rdata, rf_a, rf_b, id_a, id_b;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_sext, branch_target;

    alu_op_e     dec_op;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_src_imm;
    logic [4:0]  dec_dest;
    logic [31:0] dec_imm;
    logic        uses_rs, uses_rt, is_beq, is_bne, is_j, is_jr;
    logic        ex_dep, mem_load_dep, stall, taken;

    logic [31:0] ex_a, ex_b, ex_b_op, ex_result, div_quot, div_rem;

    assign pc       = pc_q;
    assign ID_instr = if_id_q.instr;
    assign opcode   = ID_instr[31:26];
    assign funct    = ID_instr[5:0];
    assign wb_wd    = mem_wb_q.wd;
    assign id_rs    = ID_instr[25:21];
    assign id_rt    = ID_instr[20:16];
    assign id_rd    = ID_instr[15:11];
    assign id_sext  = {{16{ID_instr[15]}}, ID_instr[15:0]};

    mips_byte_mem #(.BYTES(IMEM_BYTES)) InstrMem (
        .clk(clk), .we(1'b0), .addr(pc_q), .wdata(32'd0), .rdata(imem_rdata)
    );

    mips_byte_mem #(.BYTES(DMEM_BYTES)) dataMEM (
        .clk(clk), .we(ex_mem_q.mem_write && !rst), .addr(ex_mem_q.result),
        .wdata(ex_mem_q.store), .rdata(dmem_rdata)
    );

    mips_reg_file reg_file (
        .clk(clk), .we(mem_wb_q.reg_write && !rst), .waddr(mem_wb_q.dest),
        .wdata(mem_wb_q.wd), .raddr_a(id_rs), .raddr_b(id_rt),
        .rdata_a(rf_a), .rdata_b(rf_b)
    );

    always_comb begin
        dec_op        = ALU_NONE;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_src_imm   = 1'b0;
        dec_dest      = id_rd;
        dec_imm       = id_sext;
        uses_rs       = 1'b0;
        uses_rt       = 1'b0;
        is_beq        = 1'b0;
        is_bne        = 1'b0;
        is_j          = 1'b0;
        is_jr         = 1'b0;
        case (opcode)
            6'd0: begin
                case (funct)
                    6'd32: begin dec_op = ALU_ADD; dec_reg_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                    6'd34: begin dec_op = ALU_SUB; dec_reg_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                    6'd36: begin dec_op = ALU_AND; dec_reg_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                    6'd37: begin dec_op = ALU_OR;  dec_reg_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                    6'd42: begin dec_op = ALU_SLT; dec_reg_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
                    6'd0:  begin dec_op = ALU_SLL; dec_reg_write = 1'b1; uses_rt = 1'b1; end
                    6'd8:  begin is_jr = 1'b1; uses_rs = 1'b1; end
                    6'd27: begin dec_op = ALU_DIVU; uses_rs = 1'b1; uses_rt = 1'b1; end
                    6'd16: begin dec_op = ALU_MFHI; dec_reg_write = 1'b1; end
                    6'd18: begin dec_op = ALU_MFLO; dec_reg_write = 1'b1; end
                    default: ;
                endcase
            end
            6'd35: begin
                dec_op = ALU_ADD; dec_reg_write = 1'b1; dec_mem_read = 1'b1;
                dec_src_imm = 1'b1; dec_dest = id_rt; uses_rs = 1'b1;
            end
            6'd43: begin
                dec_op = ALU_ADD; dec_mem_write = 1'b1; dec_src_imm = 1'b1;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            6'd4:  begin is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'd5:  begin is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'd13: begin
                dec_op = ALU_OR; dec_reg_write = 1'b1; dec_src_imm = 1'b1;
                dec_dest = id_rt; dec_imm = {16'd0, ID_instr[15:0]}; uses_rs = 1'b1;
            end
            6'd2:  is_j = 1'b1;
            default: ;
        endcase
    end

    // Branch/JR operands need results still in flight; EX/MEM loads are not forwarded here.
    always_comb begin
        id_a = rf_a;
        if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.dest == id_rs) id_a = ex_mem_q.result;
        else if (mem_wb_q.reg_write && mem_wb_q.dest == id_rs) id_a = mem_wb_q.wd;
        id_b = rf_b;
        if (ex_mem_q.reg_write && !ex_mem_q.mem_read && ex_mem_q.dest == id_rt) id_b = ex_mem_q.result;
        else if (mem_wb_q.reg_write && mem_wb_q.dest == id_rt) id_b = mem_wb_q.wd;
    end

    always_comb begin
        ex_dep       = id_ex_q.reg_write &&
                       ((uses_rs && id_ex_q.dest == id_rs) || (uses_rt && id_ex_q.dest == id_rt));
        mem_load_dep = ex_mem_q.reg_write && ex_mem_q.mem_read &&
                       ((uses_rs && ex_mem_q.dest == id_rs) || (uses_rt && ex_mem_q.dest == id_rt));
        stall = (ex_dep && id_ex_q.mem_read) ||
                ((is_beq || is_bne || is_jr) && (ex_dep || mem_load_dep));
        taken = !stall && ((is_beq && id_a == id_b) || (is_bne && id_a != id_b) || is_j || is_jr);
        if (is_j)       branch_target = {if_id_q.pc4[31:28], ID_instr[25:0], 2'b00};
        else if (is_jr) branch_target = id_a;
        else            branch_target = if_id_q.pc4 + (id_sext << 2);
    end

    always_comb begin
        pc_d          = pc_q + 32'd4;
        if_id_d.instr = imem_rdata;
        if_id_d.pc4   = pc_q + 32'd4;
        if (stall) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
        end else if (taken) begin
            pc_d          = branch_target;
            if_id_d.instr = 32'd0;
        end

        id_ex_d.op        = dec_op;
        id_ex_d.reg_write = dec_reg_write && (dec_dest != 5'd0);
        id_ex_d.mem_read  = dec_mem_read;
        id_ex_d.mem_write = dec_mem_write;
        id_ex_d.src_imm   = dec_src_imm;
        id_ex_d.rs        = id_rs;
        id_ex_d.rt        = id_rt;
        id_ex_d.dest      = dec_dest;
        id_ex_d.shamt     = ID_instr[10:6];
        id_ex_d.rs_val    = id_a;
        id_ex_d.rt_val    = id_b;
        id_ex_d.imm       = dec_imm;
        if (stall) id_ex_d = '0;
    end

    always_comb begin
        ex_a = id_ex_q.rs_val;
        if (ex_mem_q.reg_write && ex_mem_q.dest == id_ex_q.rs) ex_a = ex_mem_q.result;
        else if (mem_wb_q.reg_write && mem_wb_q.dest == id_ex_q.rs) ex_a = mem_wb_q.wd;
        ex_b = id_ex_q.rt_val;
        if (ex_mem_q.reg_write && ex_mem_q.dest == id_ex_q.rt) ex_b = ex_mem_q.result;
        else if (mem_wb_q.reg_write && mem_wb_q.dest == id_ex_q.rt) ex_b = mem_wb_q.wd;
        ex_b_op = id_ex_q.src_imm ? id_ex_q.imm : ex_b;

        div_quot = (ex_b == 32'd0) ? 32'hFFFF_FFFF : ex_a / ex_b;
        div_rem  = (ex_b == 32'd0) ? ex_a : ex_a % ex_b;

        case (id_ex_q.op)
            ALU_ADD:  ex_result = ex_a + ex_b_op;
            ALU_SUB:  ex_result = ex_a - ex_b_op;
            ALU_AND:  ex_result = ex_a & ex_b_op;
            ALU_OR:   ex_result = ex_a | ex_b_op;
            ALU_SLT:  ex_result = {31'd0, $signed(ex_a) < $signed(ex_b_op)};
            ALU_SLL:  ex_result = ex_b << id_ex_q.shamt;
            ALU_MFHI: ex_result = hi_q;
            ALU_MFLO: ex_result = lo_q;
            default:  ex_result = 32'd0;
        endcase

        hi_d = hi_q;
        lo_d = lo_q;
        if (id_ex_q.op == ALU_DIVU) begin
            hi_d = div_rem;
            lo_d = div_quot;
        end

        ex_mem_d.reg_write = id_ex_q.reg_write;
        ex_mem_d.mem_read  = id_ex_q.mem_read;
        ex_mem_d.mem_write = id_ex_q.mem_write;
        ex_mem_d.dest      = id_ex_q.dest;
        ex_mem_d.result    = ex_result;
        ex_mem_d.store     = ex_b;
    end

    always_comb begin
        mem_wb_d.reg_write = ex_mem_q.reg_write;
        mem_wb_d.dest      = ex_mem_q.dest;
        mem_wb_d.wd        = 32'd0;
        if (ex_mem_q.reg_write) mem_wb_d.wd = ex_mem_q.mem_read ? dmem_rdata : ex_mem_q.result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end
endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// Directed bench for mips_pipeline_cpu: hand-assembled programs, checks of pc,
// ID_instr, wb_wd, register file and data memory at fixed cycle offsets.

module tb_mips_pipeline_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   check_count = 0;
    int   pass_count  = 0;

    mips_pipeline_cpu #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd,
                                           input int sh, input int fn);
        logic [31:0] w;
        w = {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
        return w;
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] j_type(input int op, input int target);
        logic [31:0] w;
        w = {op[5:0], target[25:0]};
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    task automatic put_instr(input int addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.InstrMem.mem_array[addr + k] = w[8*k +: 8];
    endtask

    task automatic put_data(input int addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.dataMEM.mem_array[addr + k] = w[8*k +: 8];
    endtask

    function automatic logic [31:0] data_word(input int addr);
        return {dut.dataMEM.mem_array[addr + 3], dut.dataMEM.mem_array[addr + 2],
                dut.dataMEM.mem_array[addr + 1], dut.dataMEM.mem_array[addr]};
    endfunction

    task automatic set_reg(input int r, input logic [31:0] v);
        dut.reg_file.file_array[r] = v;
    endtask

    function automatic logic [31:0] get_reg(input int r);
        return dut.reg_file.file_array[r];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset long enough to flush the pipe, then blank the program memory.
    task automatic applyStimulus();
        rst = 1'b1;
        step(2);
        for (int k = 0; k < 1024; k++) dut.InstrMem.mem_array[k] = 8'h00;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        set_reg(0, 32'd0);

        $display("[TB] ALU chain with forwarding");
        applyStimulus();
        set_reg(1, 32'd5);
        set_reg(2, 32'd3);
        for (int r = 3; r <= 7; r++) set_reg(r, 32'hFFFF_FFFF);
        put_instr(0,  r_type(1, 2, 3, 0, 32));
        put_instr(4,  r_type(3, 2, 4, 0, 34));
        put_instr(8,  r_type(3, 4, 5, 0, 36));
        put_instr(12, r_type(3, 4, 6, 0, 37));
        put_instr(16, r_type(4, 3, 7, 0, 42));
        rst = 1'b0;
        step(4); checkOutput("alu_wb_add", dut.wb_wd, 32'd8);
        step(1); checkOutput("alu_wb_sub", dut.wb_wd, 32'd5);
        step(1); checkOutput("alu_wb_and", dut.wb_wd, 32'd0);
        step(1); checkOutput("alu_wb_or",  dut.wb_wd, 32'd13);
        step(1); checkOutput("alu_wb_slt", dut.wb_wd, 32'd1);
        step(2);
        checkOutput("alu_r3", get_reg(3), 32'd8);
        checkOutput("alu_r4", get_reg(4), 32'd5);
        checkOutput("alu_r5", get_reg(5), 32'd0);
        checkOutput("alu_r6", get_reg(6), 32'd13);
        checkOutput("alu_r7", get_reg(7), 32'd1);

        $display("[TB] load-use stall and store");
        applyStimulus();
        put_data(0, 32'h0000_002A);
        put_data(4, 32'hFFFF_FFFF);
        set_reg(1, 32'd0);
        set_reg(2, 32'd0);
        put_instr(0, i_type(35, 0, 1, 0));
        put_instr(4, r_type(1, 1, 2, 0, 32));
        put_instr(8, i_type(43, 0, 2, 4));
        rst = 1'b0;
        step(3); checkOutput("lu_pc_held",  dut.pc,    32'd8);
        step(1); checkOutput("lu_wb_load",  dut.wb_wd, 32'h0000_002A);
        step(1); checkOutput("lu_wb_bubble", dut.wb_wd, 32'd0);
        step(1); checkOutput("lu_wb_add",   dut.wb_wd, 32'h0000_0054);
        step(3);
        checkOutput("lu_r2", get_reg(2), 32'h0000_0054);
        checkOutput("lu_dmem4", data_word(4), 32'h0000_0054);

        $display("[TB] BEQ taken, BNE not taken");
        applyStimulus();
        set_reg(1, 32'd7);
        for (int r = 2; r <= 5; r++) set_reg(r, 32'd0);
        put_instr(0,  i_type(4, 1, 1, 2));
        put_instr(4,  i_type(13, 0, 2, 1));
        put_instr(8,  i_type(13, 0, 3, 2));
        put_instr(12, i_type(13, 0, 4, 3));
        put_instr(16, i_type(5, 1, 1, 5));
        put_instr(20, i_type(13, 0, 5, 4));
        rst = 1'b0;
        step(2);
        checkOutput("beq_pc_target", dut.pc, 32'd12);
        checkOutput("beq_id_bubble", dut.ID_instr, 32'd0);
        step(3);
        checkOutput("bne_pc_fallthru", dut.pc, 32'd24);
        checkOutput("bne_id_next", dut.ID_instr, i_type(13, 0, 5, 4));
        step(6);
        checkOutput("beq_r2_skipped", get_reg(2), 32'd0);
        checkOutput("beq_r3_skipped", get_reg(3), 32'd0);
        checkOutput("beq_r4_target",  get_reg(4), 32'd3);
        checkOutput("bne_r5",         get_reg(5), 32'd4);

        $display("[TB] J and JR");
        applyStimulus();
        for (int r = 6; r <= 8; r++) set_reg(r, 32'd0);
        set_reg(31, 32'd0);
        put_instr(32'h00, j_type(2, 32'h10));
        put_instr(32'h04, i_type(13, 0, 6, 9));
        put_instr(32'h40, i_type(13, 0, 31, 32'h20));
        put_instr(32'h44, r_type(31, 0, 0, 0, 8));
        put_instr(32'h48, i_type(13, 0, 7, 5));
        put_instr(32'h20, i_type(13, 0, 8, 6));
        rst = 1'b0;
        step(2);
        checkOutput("j_pc",        dut.pc, 32'h40);
        checkOutput("j_id_bubble", dut.ID_instr, 32'd0);
        step(3);
        checkOutput("jr_pc_stall", dut.pc, 32'h48);
        checkOutput("jr_id_held",  dut.ID_instr, r_type(31, 0, 0, 0, 8));
        step(1);
        checkOutput("jr_pc",        dut.pc, 32'h20);
        checkOutput("jr_id_bubble", dut.ID_instr, 32'd0);
        step(6);
        checkOutput("j_r6_squashed",  get_reg(6), 32'd0);
        checkOutput("jr_r7_squashed", get_reg(7), 32'd0);
        checkOutput("jr_r8_target",   get_reg(8), 32'd6);
        checkOutput("jr_r31",         get_reg(31), 32'h20);

        $display("[TB] DIVU, MFHI, MFLO, SLL, ORI");
        applyStimulus();
        for (int r = 3; r <= 5; r++) set_reg(r, 32'h1234_5678);
        set_reg(9,  32'h1234_5678);
        set_reg(10, 32'h1234_5678);
        put_instr(0,  i_type(13, 0, 1, 17));
        put_instr(4,  i_type(13, 0, 2, 5));
        put_instr(8,  r_type(1, 2, 0, 0, 27));
        put_instr(12, r_type(0, 0, 3, 0, 18));
        put_instr(16, r_type(0, 0, 4, 0, 16));
        put_instr(20, r_type(0, 3, 5, 4, 0));
        put_instr(24, r_type(1, 0, 0, 0, 27));
        put_instr(28, r_type(0, 0, 9, 0, 18));
        put_instr(32, r_type(0, 0, 10, 0, 16));
        rst = 1'b0;
        step(7); checkOutput("div_wb_mflo", dut.wb_wd, 32'd3);
        step(1); checkOutput("div_wb_mfhi", dut.wb_wd, 32'd2);
        step(1); checkOutput("div_wb_sll",  dut.wb_wd, 32'd48);
        step(8);
        checkOutput("div_r3_lo",   get_reg(3),  32'd3);
        checkOutput("div_r4_hi",   get_reg(4),  32'd2);
        checkOutput("div_r5_sll",  get_reg(5),  32'd48);
        checkOutput("div0_r9_lo",  get_reg(9),  32'hFFFF_FFFF);
        checkOutput("div0_r10_hi", get_reg(10), 32'd17);

        $display("[TB] reset mid-run and writes to $0");
        applyStimulus();
        set_reg(11, 32'd0);
        set_reg(12, 32'd99);
        put_instr(0, i_type(13, 0, 11, 32'h55));
        put_instr(4, i_type(13, 0, 0, 7));
        put_instr(8, r_type(0, 0, 12, 0, 32));
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        checkOutput("rst_pc",        dut.pc, 32'd0);
        checkOutput("rst_id_instr",  dut.ID_instr, 32'd0);
        checkOutput("rst_wb_wd",     dut.wb_wd, 32'd0);
        checkOutput("rst_r11_discard", get_reg(11), 32'd0);
        checkOutput("rst_r1_kept",   get_reg(1), 32'd17);
        checkOutput("rst_dmem0_kept", data_word(0), 32'h0000_002A);
        checkOutput("rst_dmem4_kept", data_word(4), 32'h0000_0054);
        step(1);
        checkOutput("rst_pc_hold", dut.pc, 32'd0);
        rst = 1'b0;
        step(8);
        checkOutput("rerun_r11", get_reg(11), 32'h55);
        checkOutput("zero_r0",   get_reg(0),  32'd0);
        checkOutput("zero_read_r12", get_reg(12), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
